arbitro_puertas: RTL and testbench

- Shares a single WIDTH-bit bitwise gate unit (AND/NAND/OR/NOR/NOT/XOR/XNOR) between NUM_REQ requesters.
- Requesters use valid/ready request and response channels. Access is granted round-robin.
- The block sequences each operation through an IDLE/CALC/RESP state machine.
- It sits between client blocks and the gate datapath, which clients no longer drive directly.

---
 rtl/arbitro_puertas_pkg.sv | 21 ++
 rtl/arbitro_puertas_puertas_bus.sv | 27 ++
 rtl/arbitro_puertas.sv | 184 ++++++++++++++++++
 tb/tb_arbitro_puertas.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/arbitro_puertas_pkg.sv
// Shared definitions for the arbitro_puertas gate arbiter.
//   - 3-bit opcode constants for the bitwise gate unit
//   - FSM state encoding (IDLE / CALC / RESP)
package arbitro_puertas_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_NOT  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/arbitro_puertas_puertas_bus.sv
// puertas_bus: combinational WIDTH-bit bitwise gate unit.
// Ports:
//   a_i, b_i    operands
//   and_o .. xnor_o   all seven gate results in parallel (not_o = ~a_i)
module puertas_bus #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] nand_o,
    output logic [WIDTH-1:0] or_o,
    output logic [WIDTH-1:0] nor_o,
    output logic [WIDTH-1:0] not_o,
    output logic [WIDTH-1:0] xor_o,
    output logic [WIDTH-1:0] xnor_o
);

    assign and_o  = a_i & b_i;
    assign nand_o = ~(a_i & b_i);
    assign or_o   = a_i | b_i;
    assign nor_o  = ~(a_i | b_i);
    assign not_o  = ~a_i;
    assign xor_o  = a_i ^ b_i;
    assign xnor_o = ~(a_i ^ b_i);

endmodule

// File: rtl/arbitro_puertas.sv
// arbitro_puertas: round-robin arbiter sharing one puertas_bus gate unit
// between NUM_REQ requesters over valid/ready request/response channels.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req_valid/o_req_ready   per-requester request handshake
//   i_req_a/i_req_b           packed operands, requester k at [k*WIDTH +: WIDTH]
//   i_req_op                  packed opcodes, requester k at [k*3 +: 3]
//   o_rsp_valid/i_rsp_ready   per-requester response handshake (valid is one-hot)
//   o_rsp_data                shared result, qualified by o_rsp_valid
//   o_busy                    high whenever the FSM is not IDLE
//   o_rsp_err                 only with ARBITRO_PUERTAS_OP_ERR_EN: flags op 7
//
// Build option: define ARBITRO_PUERTAS_OP_ERR_EN to add o_rsp_err.
//
// state | meaning
// IDLE  | arbitrate; grant one valid requester and latch its operands
// CALC  | latched operands through gate unit, register result
// RESP  | present result to owner until its i_rsp_ready
module arbitro_puertas
    import arbitro_puertas_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
    input  logic [NUM_REQ*3-1:0]   i_req_op,
    output logic [NUM_REQ-1:0]     o_rsp_valid,
    input  logic [NUM_REQ-1:0]     i_rsp_ready,
    output logic [WIDTH-1:0]       o_rsp_data,
`ifdef ARBITRO_PUERTAS_OP_ERR_EN
    output logic                   o_rsp_err,
`endif
    output logic                   o_busy
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;

    logic [GW-1:0]      winner;
    logic               any_valid;
    int                 idx;

    logic [WIDTH-1:0] g_and, g_nand, g_or, g_nor, g_not, g_xor, g_xnor;
    logic [WIDTH-1:0] gate_res;

    puertas_bus #(.WIDTH(WIDTH)) u_puertas_bus (
        .a_i    (a_q),
        .b_i    (b_q),
        .and_o  (g_and),
        .nand_o (g_nand),
        .or_o   (g_or),
        .nor_o  (g_nor),
        .not_o  (g_not),
        .xor_o  (g_xor),
        .xnor_o (g_xnor)
    );

    always_comb begin
        gate_res = '0;
        case (op_q)
            OP_AND:  gate_res = g_and;
            OP_NAND: gate_res = g_nand;
            OP_OR:   gate_res = g_or;
            OP_NOR:  gate_res = g_nor;
            OP_NOT:  gate_res = g_not;
            OP_XOR:  gate_res = g_xor;
            OP_XNOR: gate_res = g_xnor;
            default: gate_res = '0;
        endcase
    end

    // Round-robin search starting just after last_grant. Scanning from the
    // farthest offset down lets the nearest valid requester overwrite.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        idx       = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (i_req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = GW'(idx);
            end
        end
    end

    // Ready is also masked by reset so every output reads 0 while held in reset.
    always_comb begin
        o_req_ready = '0;
        if (state_q == IDLE && any_valid && i_rst_n)
            o_req_ready[winner] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_d          = i_req_a[int'(winner)*WIDTH +: WIDTH];
                    b_d          = i_req_b[int'(winner)*WIDTH +: WIDTH];
                    op_d         = i_req_op[int'(winner)*3 +: 3];
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = CALC;
                end
            end
            CALC: begin
                rsp_data_d           = gate_res;
                rsp_valid_d          = '0;
                rsp_valid_d[grant_q] = 1'b1;
                rsp_err_d            = (op_q == OP_RSVD);
                state_d              = RESP;
            end
            RESP: begin
                if (i_rsp_ready[grant_q]) begin
                    rsp_valid_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GW'(NUM_REQ - 1);
            grant_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = (state_q != IDLE);
`ifdef ARBITRO_PUERTAS_OP_ERR_EN
    assign o_rsp_err   = rsp_err_q;
`else
    // Without the error port op 7 simply returns zeros; the flag is unused.
    logic unused_err;
    assign unused_err  = rsp_err_q;
`endif

endmodule

// File: tb/tb_arbitro_puertas.sv
module tb_arbitro_puertas;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_a, req_b;
    logic [5:0] req_op;
    logic [3:0] rsp_data;
    logic       busy;
`ifdef ARBITRO_PUERTAS_OP_ERR_EN
    logic       rsp_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arbitro_puertas #(.NUM_REQ(2), .WIDTH(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_op    (req_op),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
`ifdef ARBITRO_PUERTAS_OP_ERR_EN
        .o_rsp_err   (rsp_err),
`endif
        .o_busy      (busy)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] exp;
        logic       err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'b1100, 4'b1010, 3'd0, 4'b1000, 1'b0};
        vecs[1] = '{4'b1100, 4'b1010, 3'd1, 4'b0111, 1'b0};
        vecs[2] = '{4'b1100, 4'b1010, 3'd2, 4'b1110, 1'b0};
        vecs[3] = '{4'b1100, 4'b1010, 3'd3, 4'b0001, 1'b0};
        vecs[4] = '{4'b1100, 4'b1010, 3'd4, 4'b0011, 1'b0};
        vecs[5] = '{4'b1100, 4'b1010, 3'd5, 4'b0110, 1'b0};
        vecs[6] = '{4'b1100, 4'b1010, 3'd6, 4'b1001, 1'b0};
        vecs[7] = '{4'b1100, 4'b1010, 3'd7, 4'b0000, 1'b1};
        vecs[8] = '{4'b0101, 4'b0011, 3'd1, 4'b1110, 1'b0};
        vecs[9] = '{4'b0101, 4'b0011, 3'd4, 4'b1010, 1'b0};

        // Reset hold with both requesters valid
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a     = {4'b0011, 4'b1100};
        req_b     = {4'b0101, 4'b1010};
        req_op    = {3'd5, 3'd0};
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
`ifdef ARBITRO_PUERTAS_OP_ERR_EN
        chk("rst_err", 32'(rsp_err), 32'h0);
`endif
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);

        // Fairness: both valid, responses always accepted
        rsp_ready = 2'b11;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] oh;
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("fair_ready", 32'(req_ready), 32'(oh));
            step();
            chk("fair_calc_busy", 32'(busy), 32'h1);
            step();
            chk("fair_rsp_valid", 32'(rsp_valid), 32'(oh));
            chk("fair_rsp_data", 32'(rsp_data), (k % 2 == 0) ? 32'h8 : 32'h6);
            step();
        end

        // Backpressure on requester 0 while requester 1 waits
        req_op    = {3'd5, 3'd2};
        rsp_ready = 2'b10;
        req_valid = 2'b11;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'h1);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_data", 32'(rsp_data), 32'he);
            chk("bp_busy", 32'(busy), 32'h1);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            step();
        end
        rsp_ready = 2'b01;
        step();
        chk("bp_idle", 32'(busy), 32'h0);
        chk("bp_grant1", 32'(req_ready), 32'h2);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        chk("bp_r1_valid", 32'(rsp_valid), 32'h2);
        chk("bp_r1_data", 32'(rsp_data), 32'h6);
        rsp_ready = 2'b10;
        step();
        chk("bp_r1_done", 32'(rsp_valid), 32'h0);

        // Table-driven op sweep on requester 0
        for (int i = 0; i < 10; i++) begin
            req_a[3:0]  = vecs[i].a;
            req_b[3:0]  = vecs[i].b;
            req_op[2:0] = vecs[i].op;
            req_valid   = 2'b01;
            rsp_ready   = 2'b00;
            #1;
            chk("vec_ready", 32'(req_ready), 32'h1);
            step();
            req_valid  = 2'b00;
            req_a[3:0] = ~vecs[i].a;
            req_op[2:0] = 3'd7 - vecs[i].op;
            #1;
            chk("vec_calc_valid", 32'(rsp_valid), 32'h0);
            chk("vec_calc_busy", 32'(busy), 32'h1);
            step();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[i].exp));
`ifdef ARBITRO_PUERTAS_OP_ERR_EN
            chk("vec_rsp_err", 32'(rsp_err), 32'(vecs[i].err));
`endif
            rsp_ready = 2'b01;
            step();
            chk("vec_done_valid", 32'(rsp_valid), 32'h0);
            chk("vec_done_busy", 32'(busy), 32'h0);
        end

        // Reset asserted while in CALC
        req_a[3:0]  = 4'b1100;
        req_b[3:0]  = 4'b1010;
        req_op[2:0] = 3'd0;
        req_valid   = 2'b01;
        rsp_ready   = 2'b01;
        #1;
        step();
        chk("rc_in_calc", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rc_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rc_busy", 32'(busy), 32'h0);
        chk("rc_data", 32'(rsp_data), 32'h0);
        chk("rc_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rc_no_rsp", 32'(rsp_valid), 32'h0);
        end
        req_valid = 2'b11;
        #1;
        chk("rc_restart_r0", 32'(req_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
